delay_and_sum_udiv_seq: RTL and testbench



---
 rtl/delay_and_sum_udiv_seq_pkg.sv | 17 +
 rtl/delay_and_sum_udiv_seq_if.sv | 30 +++
 rtl/delay_and_sum_udiv_step.sv | 29 ++
 rtl/delay_and_sum_udiv_seq.sv | 106 ++++++++++
 tb/tb_delay_and_sum_udiv_seq.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/delay_and_sum_udiv_seq_pkg.sv
// Shared types and default widths for the DelayAndSum unsigned divider family
// (sequential top and the reusable single restoring step).
package delay_and_sum_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DAS_DIV_DIVIDEND_W = 28;
  localparam int DAS_DIV_DIVISOR_W  = 17;

  // Wide enough for any dividend width; truncated to the dividend width at use.
  localparam logic [63:0] DAS_DIV_DBZ_QUOTIENT = '1;

endpackage

// File: rtl/delay_and_sum_udiv_seq_if.sv
// Operand/result handshake bundle for the sequential unsigned divider.
// master drives operands and out_ready; slave is the divider.
interface delay_and_sum_udiv_seq_if
  import delay_and_sum_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DAS_DIV_DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DAS_DIV_DIVISOR_W
);

  logic                      in_valid;
  logic                      in_ready;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIVIDEND_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;
  logic                      div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/delay_and_sum_udiv_step.sv
// One combinational radix-2 restoring division step: shift the next dividend
// bit into the partial remainder, subtract the divisor if it fits.
module delay_and_sum_udiv_step
  import delay_and_sum_div_pkg::*;
#(
  parameter int DIVISOR_WIDTH = DAS_DIV_DIVISOR_W
) (
  input  logic [DIVISOR_WIDTH-1:0] p_in,
  input  logic                     q_msb,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH-1:0] p_out,
  output logic                     q_bit
);

  logic [DIVISOR_WIDTH:0] t;

  assign t = {p_in, q_msb};

  // p_in < divisor holds between steps, so the difference always fits back
  // into DIVISOR_WIDTH bits and the extra compare bit prevents overflow.
  always_comb begin
    q_bit = (t >= {1'b0, divisor});
    p_out = t[DIVISOR_WIDTH-1:0];
    if (q_bit) begin
      p_out = DIVISOR_WIDTH'(t - {1'b0, divisor});
    end
  end

endmodule

// File: rtl/delay_and_sum_udiv_seq.sv
// Iterative unsigned divider, one quotient bit per cycle; result valid
// DIVIDEND_WIDTH cycles after accept (next cycle for a zero divisor), held until out_ready.
module delay_and_sum_udiv_seq
  import delay_and_sum_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DAS_DIV_DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DAS_DIV_DIVISOR_W,
  parameter int CNT_WIDTH      = 5
) (
  input logic                     ap_clk,
  input logic                     ap_rst,
  delay_and_sum_udiv_seq_if.slave bus
);

  div_state_t                state;
  div_state_t                state_nxt;
  logic [CNT_WIDTH-1:0]      cnt;
  logic [DIVISOR_WIDTH-1:0]  p;
  logic [DIVIDEND_WIDTH-1:0] q;
  logic [DIVISOR_WIDTH-1:0]  dsr;
  logic                      dbz;
  logic [DIVISOR_WIDTH-1:0]  p_nxt;
  logic                      q_bit;
  logic                      accept;
  logic                      zero_divisor;

  assign zero_divisor = (bus.divisor == '0);

  delay_and_sum_udiv_step #(
    .DIVISOR_WIDTH (DIVISOR_WIDTH)
  ) u_step (
    .p_in    (p),
    .q_msb   (q[DIVIDEND_WIDTH-1]),
    .divisor (dsr),
    .p_out   (p_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = zero_divisor ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt == CNT_WIDTH'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // q doubles as the quotient output and p as the remainder output, so the
  // result stays frozen in DONE without separate output registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt <= '0;
      p   <= '0;
      q   <= '0;
      dsr <= '0;
      dbz <= 1'b0;
    end else if (accept) begin
      dsr <= bus.divisor;
      if (zero_divisor) begin
        q   <= DIVIDEND_WIDTH'(DAS_DIV_DBZ_QUOTIENT);
        p   <= bus.dividend[DIVISOR_WIDTH-1:0];
        cnt <= '0;
        dbz <= 1'b1;
      end else begin
        q   <= bus.dividend;
        p   <= '0;
        cnt <= CNT_WIDTH'(DIVIDEND_WIDTH);
        dbz <= 1'b0;
      end
    end else if (state == BUSY) begin
      p   <= p_nxt;
      q   <= {q[DIVIDEND_WIDTH-2:0], q_bit};
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = q;
  assign bus.remainder   = p;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_delay_and_sum_udiv_seq.sv
// Directed and randomised checks of the sequential unsigned divider.
module tb_delay_and_sum_udiv_seq;
  import delay_and_sum_div_pkg::*;

  localparam int DW = 28;
  localparam int DS = 17;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 ap_clk = ~ap_clk;

  delay_and_sum_udiv_seq_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(DS)) bus ();

  delay_and_sum_udiv_seq #(
    .DIVIDEND_WIDTH (DW),
    .DIVISOR_WIDTH  (DS),
    .CNT_WIDTH      (5)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge with the divider idle; returns at the negedge after the accept edge.
  task automatic start(input logic [DW-1:0] dd, input logic [DS-1:0] dv);
    chk("in_ready_before_accept", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    @(negedge ap_clk);
    bus.in_valid = 1'b0;
    bus.dividend = DW'($urandom());
    bus.divisor  = DS'($urandom());
  endtask

  task automatic wait_result(output int n, output bit rdy_seen);
    n = 0;
    rdy_seen = 1'b0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      if (bus.in_ready !== 1'b0) rdy_seen = 1'b1;
      @(negedge ap_clk);
      n++;
    end
    if (bus.in_ready !== 1'b0) rdy_seen = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic [DW-1:0] dd, input logic [DS-1:0] dv,
                        input logic [DW-1:0] exp_q, input logic [DS-1:0] exp_r,
                        input logic exp_dbz, input int exp_lat);
    int n;
    bit rdy_seen;
    bus.out_ready = 1'b1;
    start(dd, dv);
    wait_result(n, rdy_seen);
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_in_ready_low"}, 64'(rdy_seen), 0);
    chk({tag, "_quotient"}, bus.quotient, exp_q);
    chk({tag, "_remainder"}, bus.remainder, exp_r);
    chk({tag, "_dbz"}, bus.div_by_zero, exp_dbz);
    @(negedge ap_clk);
    chk({tag, "_out_valid_drop"}, bus.out_valid, 0);
    chk({tag, "_in_ready_back"}, bus.in_ready, 1);
  endtask

  initial begin
    int n;
    bit rdy_seen;
    bit seen_valid;
    logic [DW-1:0] dd;
    logic [DS-1:0] dv;
    logic [DW-1:0] q_hold;
    logic [DS-1:0] r_hold;
    logic [63:0]   recon;

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge ap_clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);

    run_op("div_1000000_3", 28'd1000000, 17'd3, 28'd333333, 17'd1, 1'b0, 28);
    run_op("div_max_1", 28'd268435455, 17'd1, 28'd268435455, 17'd0, 1'b0, 28);
    run_op("div_max_maxdv", 28'd268435455, 17'd131071, 28'd2048, 17'd2047, 1'b0, 28);
    run_op("div_by_zero", 28'd12345, 17'd0, 28'hFFFFFFF, 17'd12345, 1'b1, 0);
    run_op("div_zero_dividend", 28'd0, 17'd5, 28'd0, 17'd0, 1'b0, 28);

    // Result held under backpressure while inputs churn.
    bus.out_ready = 1'b0;
    start(28'd500, 17'd1000);
    wait_result(n, rdy_seen);
    chk("stall_latency", 64'(n), 28);
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      bus.in_valid = i[0];
      bus.dividend = DW'($urandom());
      bus.divisor  = DS'($urandom());
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_quotient", bus.quotient, 0);
      chk("stall_remainder", bus.remainder, 500);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge ap_clk);
    chk("stall_release_valid", bus.out_valid, 0);
    chk("stall_release_ready", bus.in_ready, 1);

    // Asynchronous reset mid-operation discards the in-flight division.
    start(28'd77777, 17'd7);
    repeat (10) @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_quotient", bus.quotient, 0);
    chk("midrst_remainder", bus.remainder, 0);
    chk("midrst_dbz", bus.div_by_zero, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ap_clk);
      if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
    end
    chk("midrst_no_valid", 64'(seen_valid), 0);
    run_op("div_100_9", 28'd100, 17'd9, 28'd11, 17'd1, 1'b0, 28);

    // Random sweep against a reference division, with random result stalls.
    for (int k = 0; k < 200; k++) begin
      dd = DW'($urandom());
      case ($urandom_range(0, 7))
        0:       dv = '0;
        1:       dv = 17'd1;
        2, 3:    dv = DS'($urandom_range(1, 255));
        default: dv = DS'($urandom());
      endcase
      if ($urandom_range(0, 7) == 0) dd = DW'($urandom_range(0, 300));
      bus.out_ready = 1'b1;
      start(dd, dv);
      wait_result(n, rdy_seen);
      chk("rand_latency", 64'(n), (dv == '0) ? 64'd0 : 64'd28);
      chk("rand_in_ready_low", 64'(rdy_seen), 0);
      if (dv == '0) begin
        chk("rand_dbz_quotient", bus.quotient, 28'hFFFFFFF);
        chk("rand_dbz_remainder", bus.remainder, dd[DS-1:0]);
        chk("rand_dbz_flag", bus.div_by_zero, 1);
      end else begin
        recon = 64'(bus.quotient) * 64'(dv) + 64'(bus.remainder);
        chk("rand_reconstruct", recon, 64'(dd));
        chk("rand_rem_lt_divisor", 64'(bus.remainder < dv), 1);
        chk("rand_quotient", bus.quotient, dd / DW'(dv));
        chk("rand_dbz_flag", bus.div_by_zero, 0);
      end
      q_hold = bus.quotient;
      r_hold = bus.remainder;
      bus.out_ready = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(negedge ap_clk);
        chk("rand_hold_valid", bus.out_valid, 1);
        chk("rand_hold_quotient", bus.quotient, q_hold);
        chk("rand_hold_remainder", bus.remainder, r_hold);
      end
      bus.out_ready = 1'b1;
      @(negedge ap_clk);
      chk("rand_release", bus.out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
